// File: rtl/ascon_perm_iter_pkg.sv
// Shared ASCON types and constants: 320-bit state, S-box table, rotation amounts
// and the states of the iterative permutation controller.
package ascon_pack;

    typedef logic [4:0][63:0] type_state;

    typedef enum logic [1:0] {
        PERM_IDLE = 2'd0,
        PERM_RUN  = 2'd1,
        PERM_DONE = 2'd2
    } type_perm_fsm;

    localparam logic [4:0] C_SBOX [32] = '{
        5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
    };

    // Linear-layer rotation pairs, one entry per state word x0..x4.
    localparam int unsigned C_ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int unsigned C_ROT_B [5] = '{28, 39, 6, 17, 41};

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
        rotr64 = (x >> n) | (x << (32'd64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition, bit-sliced S-box layer,
// then the per-word linear diffusion layer.
module ascon_round
    import ascon_pack::*;
(
    input  type_state  state_i,
    input  logic [3:0] round_i,
    output type_state  state_o
);

    type_state w_add;
    type_state w_sub;

    always_comb begin
        w_add          = state_i;
        w_add[2][7:0]  = state_i[2][7:0] ^ {4'hF - round_i, round_i};
    end

    // Each bit column {x0..x4} (x0 as MSB) goes through the same 5-bit S-box.
    for (genvar gi = 0; gi < 64; gi++) begin : g_col
        logic [4:0] w_sbox_out;
        assign w_sbox_out = C_SBOX[{w_add[0][gi], w_add[1][gi], w_add[2][gi],
                                    w_add[3][gi], w_add[4][gi]}];
        assign w_sub[0][gi] = w_sbox_out[4];
        assign w_sub[1][gi] = w_sbox_out[3];
        assign w_sub[2][gi] = w_sbox_out[2];
        assign w_sub[3][gi] = w_sbox_out[1];
        assign w_sub[4][gi] = w_sbox_out[0];
    end

    for (genvar gk = 0; gk < 5; gk++) begin : g_lin
        assign state_o[gk] = w_sub[gk]
                           ^ rotr64(w_sub[gk], C_ROT_A[gk])
                           ^ rotr64(w_sub[gk], C_ROT_B[gk]);
    end

endmodule

// File: rtl/ascon_perm_iter.sv
// Iterative ASCON permutation p^N, one round per clock, result held in an
// internal 320-bit register. Optional round_o port: define ASCON_ROUND_IDX_OUT_EN.
module ascon_perm_iter
    import ascon_pack::*;
#(
    parameter int MAX_ROUNDS = 12
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [3:0] nb_rounds_i,
    input  type_state  state_i,
    output type_state  state_o,
    output logic       busy_o,
`ifdef ASCON_ROUND_IDX_OUT_EN
    output logic       done_o,
    output logic [3:0] round_o
`else
    output logic       done_o
`endif
);

    localparam logic [3:0] C_MAX  = 4'(MAX_ROUNDS);
    localparam logic [3:0] C_LAST = 4'(MAX_ROUNDS - 1);

    type_perm_fsm r_fsm;
    type_perm_fsm w_fsm_next;
    type_state    r_state;
    type_state    w_state_next;
    type_state    w_round_out;
    logic [3:0]   r_round;
    logic [3:0]   w_round_next;
    logic [3:0]   w_nb_clamped;

    ascon_round u_round (
        .state_i (r_state),
        .round_i (r_round),
        .state_o (w_round_out)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_fsm <= PERM_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next   = r_fsm;
        w_state_next = r_state;
        w_round_next = r_round;
        w_nb_clamped = (nb_rounds_i > C_MAX) ? C_MAX : nb_rounds_i;
        case (r_fsm)
            PERM_IDLE: begin
                if (start_i) begin
                    w_state_next = state_i;
                    // Starting at MAX_ROUNDS-N makes the last applied round always MAX_ROUNDS-1.
                    w_round_next = C_MAX - w_nb_clamped;
                    w_fsm_next   = (w_nb_clamped == 4'd0) ? PERM_DONE : PERM_RUN;
                end
            end
            PERM_RUN: begin
                w_state_next = w_round_out;
                w_round_next = r_round + 4'd1;
                if (r_round == C_LAST) begin
                    w_fsm_next = PERM_DONE;
                end
            end
            PERM_DONE: begin
                w_fsm_next = PERM_IDLE;
            end
            default: begin
                w_fsm_next = PERM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= '0;
            r_round <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_round <= w_round_next;
        end
    end

    assign state_o = r_state;
    assign busy_o  = (r_fsm == PERM_RUN);
    assign done_o  = (r_fsm == PERM_DONE);

`ifdef ASCON_ROUND_IDX_OUT_EN
    assign round_o = r_round;
`endif

endmodule

// File: tb/tb_ascon_perm_iter.sv
// Bench for ascon_perm_iter: random permutations compared cycle by cycle
// against a bit-level software model of the ASCON permutation.
module tb_ascon_perm_iter;

    typedef logic [4:0][63:0] st_t;

    logic       clock_i = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic [3:0] nb_rounds_i;
    st_t        state_i;
    st_t        state_o;
    logic       busy_o;
    logic       done_o;
`ifdef ASCON_ROUND_IDX_OUT_EN
    logic [3:0] round_o;
`endif

    ascon_perm_iter #(.MAX_ROUNDS(12)) dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .nb_rounds_i (nb_rounds_i),
        .state_i     (state_i),
        .state_o     (state_o),
        .busy_o      (busy_o),
`ifdef ASCON_ROUND_IDX_OUT_EN
        .done_o      (done_o),
        .round_o     (round_o)
`else
        .done_o      (done_o)
`endif
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clock_i = ~clock_i;

    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    int sb [32] = '{4, 11, 31, 20, 26, 21, 9, 2, 27, 5, 8, 18, 29, 3, 6, 28,
                    30, 19, 7, 14, 0, 13, 17, 24, 16, 12, 1, 25, 22, 10, 15, 23};
    int ra [5] = '{19, 61, 1, 10, 7};
    int rb [5] = '{28, 39, 6, 17, 41};

    function automatic st_t model_round(st_t s, int r);
        st_t t;
        st_t y;
        int  idx;
        int  o;
        s[2][7:0] = s[2][7:0] ^ 8'(((15 - r) * 16) + r);
        for (int i = 0; i < 64; i++) begin
            idx = 16 * int'(s[0][i]) + 8 * int'(s[1][i]) + 4 * int'(s[2][i])
                + 2 * int'(s[3][i]) + int'(s[4][i]);
            o = sb[idx];
            t[0][i] = o[4];
            t[1][i] = o[3];
            t[2][i] = o[2];
            t[3][i] = o[1];
            t[4][i] = o[0];
        end
        for (int k = 0; k < 5; k++)
            for (int i = 0; i < 64; i++)
                y[k][i] = t[k][i] ^ t[k][(i + ra[k]) % 64] ^ t[k][(i + rb[k]) % 64];
        return y;
    endfunction

    function automatic int clamp_n(int n);
        return (n > 12) ? 12 : n;
    endfunction

    function automatic st_t model_perm(st_t s, int n);
        for (int r = 12 - clamp_n(n); r < 12; r++) s = model_round(s, r);
        return s;
    endfunction

    // ---------------- scoreboard ----------------
    logic [319:0] exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   active   = 0;
    bit   hold_valid = 0;
    int   start_cyc = 0;
    int   exp_n = 0;
    st_t  last_res;

    task automatic check1(string name, logic got, logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got=%b exp=%b", name, cyc, got, exp);
        end
    endtask

    task automatic check64(string name, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic check320(string name, st_t got, st_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // One compare process: timing of busy/done every cycle, result at done, hold afterwards.
    always @(negedge clock_i) begin
        bit  eb;
        bit  ed;
        st_t e;
        eb = active && (cyc >= start_cyc) && (cyc < start_cyc + exp_n);
        ed = active && (cyc == start_cyc + exp_n);
        check1("busy", busy_o, eb);
        check1("done", done_o, ed);
        if (ed) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL result at cyc %0d: no expected entry queued", cyc);
            end else begin
                e = exp_q.pop_front();
                check320("result", state_o, e);
                last_res   = e;
                hold_valid = 1;
            end
`ifdef ASCON_ROUND_IDX_OUT_EN
            check64("round_idx", 64'(round_o), 64'd12);
`endif
            active = 0;
        end else if (hold_valid) begin
            check320("hold", state_o, last_res);
        end
    end

    // ---------------- driver tasks ----------------
    function automatic st_t rand_state();
        st_t s;
        for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic start_perm(st_t s, int n);
        @(negedge clock_i);
        state_i     = s;
        nb_rounds_i = 4'(n);
        start_i     = 1'b1;
        @(posedge clock_i);
        #1;
        start_i    = 1'b0;
        start_cyc  = cyc;
        exp_n      = clamp_n(n);
        exp_q.push_back(model_perm(s, n));
        hold_valid = 0;
        active     = 1;
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        do begin
            @(negedge clock_i);
            g++;
        end while (cyc != start_cyc + exp_n && g < 100);
        #1;
        if (g >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: cycle budget expired at cyc %0d", cyc);
        end
    endtask

    task automatic do_perm(st_t s, int n);
        start_perm(s, n);
        wait_done();
    endtask

    task automatic clear_model();
        active     = 0;
        hold_valid = 0;
        exp_q.delete();
    endtask

    task automatic check_zero_state(string tag);
        check320({tag, "_state"}, state_o, '0);
        check1({tag, "_busy"}, busy_o, 1'b0);
        check1({tag, "_done"}, done_o, 1'b0);
    endtask

    task automatic check_scenario2(string tag);
        check1({tag, "_done"}, done_o, 1'b1);
        check64({tag, "_x0"}, state_o[0], 64'h000964B00000004B);
        check64({tag, "_x1"}, state_o[1], 64'h0000000096000213);
        check64({tag, "_x3"}, state_o[3], 64'h12E580000000004B);
        check64({tag, "_x4"}, state_o[4], 64'h0000000000000000);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        st_t s;
        st_t pin;
        reset_i     = 1'b1;
        start_i     = 1'b0;
        nb_rounds_i = 4'd0;
        state_i     = '0;
        repeat (2) @(negedge clock_i);
        check_zero_state("reset");
        reset_i = 1'b0;

        pin = model_perm('0, 1);
        check64("model_pin_x0", pin[0], 64'h000964B00000004B);
        check64("model_pin_x1", pin[1], 64'h0000000096000213);
        check64("model_pin_x3", pin[3], 64'h12E580000000004B);

        // Single round from the zero state.
        do_perm('0, 1);
        check_scenario2("one_round");

        // Latency sweep for the standard round counts.
        do_perm(rand_state(), 6);
        do_perm(rand_state(), 8);
        do_perm(rand_state(), 12);

        // Boundary round counts.
        s = rand_state();
        do_perm(s, 0);
        check320("n0_passthrough", state_o, s);
        do_perm(s, 15);
        do_perm(s, 13);

        // New request during a run must be ignored.
        start_perm(rand_state(), 12);
        repeat (3) @(negedge clock_i);
        state_i     = rand_state();
        nb_rounds_i = 4'd1;
        start_i     = 1'b1;
        @(posedge clock_i);
        #1;
        start_i = 1'b0;
        wait_done();
        // Start during the done cycle is also ignored.
        start_perm(rand_state(), 2);
        repeat (2) @(negedge clock_i);
        start_i = 1'b1;
        state_i = rand_state();
        @(posedge clock_i);
        #1;
        start_i = 1'b0;
        repeat (4) @(negedge clock_i);

        // Randomized mix of round counts.
        for (int it = 0; it < 12; it++) do_perm(rand_state(), $urandom_range(0, 15));

        // Asynchronous reset mid-cycle with a non-zero register.
        do_perm(rand_state(), 3);
        @(posedge clock_i);
        #3;
        clear_model();
        reset_i = 1'b1;
        #1;
        check_zero_state("async_reset");
        @(negedge clock_i);
        #1;
        reset_i = 1'b0;

        // Abort during round 5 of 12: no done pulse may follow.
        start_perm(rand_state(), 12);
        repeat (5) @(posedge clock_i);
        #3;
        clear_model();
        reset_i = 1'b1;
        #1;
        check_zero_state("abort");
        @(negedge clock_i);
        #1;
        reset_i = 1'b0;
        repeat (15) @(negedge clock_i);
        do_perm('0, 1);
        check_scenario2("after_abort");
        repeat (3) @(negedge clock_i);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
